lru_state_array: RTL and testbench



---
 rtl/lru_pkg.sv | 13 +
 rtl/lru_state_array_if.sv | 32 +++
 rtl/lru_flush_ctrl.sv | 54 +++++
 rtl/lru_state_array.sv | 86 ++++++++
 tb/tb_lru_state_array.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/lru_pkg.sv
// Shared definitions for the pseudo-LRU state storage and the tree-decode stage.
// Default geometry: 4-way, 8 sets.
package lru_pkg;

  localparam int S_WAY   = 2;
  localparam int S_INDEX = 3;

  typedef enum logic [0:0] {
    LRU_IDLE  = 1'b0,
    LRU_FLUSH = 1'b1
  } lru_flush_state_t;

endpackage

// File: rtl/lru_state_array_if.sv
// Lookup / write-back / flush signal bundle between the cache pipeline and the LRU array.
// The pipeline side is master; the array side is slave.
interface lru_state_array_if
  import lru_pkg::*;
#(
  parameter int s_way   = S_WAY,
  parameter int s_index = S_INDEX
);
  localparam int num_ways = 2**s_way;

  logic                  lookup_valid;
  logic [s_index-1:0]    lookup_index;
  logic                  lookup_ready;
  logic                  lru_valid;
  logic [s_index-1:0]    lru_index;
  logic [num_ways-2:0]   lru_out;
  logic                  update_valid;
  logic [s_index-1:0]    update_index;
  logic [num_ways-2:0]   update_lru;
  logic                  flush_req;
  logic                  flush_busy;

  modport master (
    output lookup_valid, lookup_index, update_valid, update_index, update_lru, flush_req,
    input  lookup_ready, lru_valid, lru_index, lru_out, flush_busy
  );

  modport slave (
    input  lookup_valid, lookup_index, update_valid, update_index, update_lru, flush_req,
    output lookup_ready, lru_valid, lru_index, lru_out, flush_busy
  );
endinterface

// File: rtl/lru_flush_ctrl.sv
// Flush sequencer: walks every set once, one per cycle, emitting a clear strobe and index.
// flush_req is only honoured in IDLE; the counter wraps to 0 on the last set.
module lru_flush_ctrl
  import lru_pkg::*;
#(
  parameter int s_index = S_INDEX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               clr_en,
  output logic [s_index-1:0] clr_idx,
  output logic               is_idle
);
  localparam int num_sets = 2**s_index;
  localparam logic [s_index-1:0] LAST_SET = s_index'(num_sets - 1);

  lru_flush_state_t   state;
  logic [s_index-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LRU_IDLE;
      cnt        <= '0;
      flush_busy <= 1'b0;
    end else begin
      case (state)
        LRU_IDLE: begin
          if (flush_req) begin
            state      <= LRU_FLUSH;
            flush_busy <= 1'b1;
          end
        end
        LRU_FLUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_SET) begin
            state      <= LRU_IDLE;
            flush_busy <= 1'b0;
          end
        end
        default: begin
          state      <= LRU_IDLE;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en  = (state == LRU_FLUSH);
  assign clr_idx = cnt;
  assign is_idle = (state == LRU_IDLE);

endmodule

// File: rtl/lru_state_array.sv
// Per-set pseudo-LRU tree bits with a 1-cycle registered read, same-cycle write forwarding
// and a sequential flush. Tree bits are opaque here.
module lru_state_array
  import lru_pkg::*;
#(
  parameter int s_way   = S_WAY,
  parameter int s_index = S_INDEX
) (
  input  logic              clk,
  input  logic              rst_n,
  lru_state_array_if.slave  bus
);
  localparam int num_ways = 2**s_way;
  localparam int num_sets = 2**s_index;
  localparam int LW       = num_ways - 1;
  localparam int STAGES   = 1;

  logic [num_sets-1:0][LW-1:0] arr;
  logic [num_sets-1:0]         set_we;
  logic [num_sets-1:0]         set_clr;

  logic               clr_en;
  logic [s_index-1:0] clr_idx;
  logic               is_idle;
  logic               upd_en;
  logic               accept;
  logic               fwd_hit;
  logic [LW-1:0]      rd_data;
  logic [STAGES:0]    vld_pipe;

  lru_flush_ctrl #(.s_index(s_index)) u_flush (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_req  (bus.flush_req),
    .flush_busy (bus.flush_busy),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx),
    .is_idle    (is_idle)
  );

  // Updates are dropped during a flush; in IDLE an update coinciding with flush_req still lands
  // and is then swept away.
  assign upd_en = bus.update_valid && is_idle;

  for (genvar g = 0; g < num_sets; g++) begin : g_set
    assign set_clr[g] = clr_en && (clr_idx == s_index'(g));
    assign set_we[g]  = upd_en && (bus.update_index == s_index'(g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr <= '0;
    end else begin
      for (int s = 0; s < num_sets; s++) begin
        if (set_clr[s])     arr[s] <= '0;
        else if (set_we[s]) arr[s] <= bus.update_lru;
      end
    end
  end

  assign bus.lookup_ready = is_idle && !bus.flush_req;
  assign accept           = bus.lookup_valid && bus.lookup_ready;

  // A write landing on the same edge as the read must be visible to that read.
  assign fwd_hit = upd_en && (bus.update_index == bus.lookup_index);
  assign rd_data = fwd_hit ? bus.update_lru : arr[bus.lookup_index];

  assign vld_pipe[0] = accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      bus.lru_index      <= '0;
      bus.lru_out        <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (accept) begin
        bus.lru_index <= bus.lookup_index;
        bus.lru_out   <= rd_data;
      end
    end
  end

  assign bus.lru_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_lru_state_array.sv
// Directed bench for lru_state_array: scoreboard of expected lookup results, popped on lru_valid.
module tb_lru_state_array;
  import lru_pkg::*;

  localparam int SW = 2;
  localparam int SI = 3;
  localparam int NS = 2**SI;

  typedef struct packed {
    logic [SI-1:0] idx;
    logic [2:0]    lru;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  logic [2:0] mdl [NS];

  lru_state_array_if #(.s_way(SW), .s_index(SI)) bus ();

  lru_state_array #(.s_way(SW), .s_index(SI)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every lru_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.lru_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_lru_valid", 8'd1, 8'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("lru_index", 8'(bus.lru_index), 8'(e.idx));
        chk("lru_out",   8'(bus.lru_out),   8'(e.lru));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; model is updated first so a same-cycle update is forwarded.
  task automatic drive(input logic lv, input int li, input logic uv, input int ui, input logic [2:0] ud);
    exp_t e;
    bus.lookup_valid = lv;
    bus.lookup_index = SI'(li);
    bus.update_valid = uv;
    bus.update_index = SI'(ui);
    bus.update_lru   = ud;
    if (uv) mdl[ui] = ud;
    if (lv) begin
      e.idx = SI'(li);
      e.lru = mdl[li];
      exp_q.push_back(e);
    end
    cyc();
    bus.lookup_valid = 1'b0;
    bus.update_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NS; i++) mdl[i] = 3'b000;
    rst_n            = 1'b0;
    bus.lookup_valid = 1'b0;
    bus.lookup_index = '0;
    bus.update_valid = 1'b0;
    bus.update_index = '0;
    bus.update_lru   = '0;
    bus.flush_req    = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_lru_valid",  8'(bus.lru_valid),  8'd0);
    chk("rst_lru_index",  8'(bus.lru_index),  8'd0);
    chk("rst_lru_out",    8'(bus.lru_out),    8'd0);
    chk("rst_flush_busy", 8'(bus.flush_busy), 8'd0);
    rst_n = 1'b1;
    cyc();
    chk("rst_ready", 8'(bus.lookup_ready), 8'd1);

    // Lookup after reset
    drive(1'b1, 5, 1'b0, 0, 3'b000);
    chk("lookup5_valid", 8'(bus.lru_valid), 8'd1);
    idle(1);
    chk("valid_drops", 8'(bus.lru_valid), 8'd0);
    chk("hold_index",  8'(bus.lru_index), 8'd5);

    // Update then lookup via the array
    drive(1'b0, 0, 1'b1, 2, 3'b101);
    drive(1'b1, 2, 1'b0, 0, 3'b000);
    drive(1'b1, 3, 1'b0, 0, 3'b000);
    idle(1);

    // Same-cycle forwarding, then array read of the same set
    drive(1'b1, 4, 1'b1, 4, 3'b011);
    idle(1);
    drive(1'b1, 4, 1'b0, 0, 3'b000);
    idle(1);

    // Flush: fill all sets, sweep, updates/lookups during the sweep are ignored
    for (int i = 0; i < NS; i++) drive(1'b0, 0, 1'b1, i, 3'b111);
    bus.flush_req    = 1'b1;
    bus.update_valid = 1'b1;
    bus.update_index = SI'(1);
    bus.update_lru   = 3'b010;
    mdl[1] = 3'b010;
    @(negedge clk);
    chk("flush_n_ready", 8'(bus.lookup_ready), 8'd0);
    chk("flush_n_busy",  8'(bus.flush_busy),   8'd0);
    cyc();
    bus.flush_req = 1'b0;
    for (int i = 1; i <= NS; i++) begin
      bus.update_valid = 1'b1;
      bus.update_index = SI'(i - 1);
      bus.update_lru   = 3'b110;
      bus.lookup_valid = 1'b1;
      bus.lookup_index = SI'(i - 1);
      @(negedge clk);
      chk($sformatf("flush_busy_c%0d", i),  8'(bus.flush_busy),   8'd1);
      chk($sformatf("flush_ready_c%0d", i), 8'(bus.lookup_ready), 8'd0);
      cyc();
    end
    bus.update_valid = 1'b0;
    bus.lookup_valid = 1'b0;
    @(negedge clk);
    chk("flush_done_busy",  8'(bus.flush_busy),   8'd0);
    chk("flush_done_ready", 8'(bus.lookup_ready), 8'd1);
    cyc();
    for (int i = 0; i < NS; i++) mdl[i] = 3'b000;
    for (int i = 0; i < NS; i++) drive(1'b1, i, 1'b0, 0, 3'b000);
    idle(2);

    // Back-to-back lookups with distinct contents
    drive(1'b0, 0, 1'b1, 0, 3'b001);
    drive(1'b0, 0, 1'b1, 1, 3'b010);
    drive(1'b0, 0, 1'b1, 2, 3'b100);
    drive(1'b0, 0, 1'b1, 3, 3'b110);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i, 1'b0, 0, 3'b000);
      chk($sformatf("b2b_valid_%0d", i), 8'(bus.lru_valid), 8'd1);
    end
    idle(1);
    chk("b2b_end_valid", 8'(bus.lru_valid), 8'd0);

    // Reset in the middle of a flush
    drive(1'b0, 0, 1'b1, 7, 3'b101);
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    idle(2);
    chk("midflush_busy", 8'(bus.flush_busy), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("midflush_rst_busy",  8'(bus.flush_busy),   8'd0);
    chk("midflush_rst_ready", 8'(bus.lookup_ready), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("after_rst_ready", 8'(bus.lookup_ready), 8'd1);
    chk("after_rst_busy",  8'(bus.flush_busy),   8'd0);
    for (int i = 0; i < NS; i++) mdl[i] = 3'b000;
    for (int i = 0; i < NS; i++) drive(1'b1, i, 1'b0, 0, 3'b000);
    idle(3);

    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
